// File: rtl/seq_divider.sv
// seq_divider: 12-bit by 6-bit unsigned restoring divider with a 6-bit quotient.
// Operands are latched on the accepting edge. A CHECK state screens for
// divide-by-zero and quotient overflow, then RUN performs six restoring steps.
module seq_divider (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [11:0] dividend,
  input  logic [5:0]  divisor,
  output logic        busy,
  output logic        done,
  output logic [5:0]  quotient,
  output logic [5:0]  remainder,
  output logic        dz,
  output logic        ovf
);

  typedef enum logic [1:0] {IDLE, CHECK, RUN, FIN} state_e;

  state_e      state_q, state_d;
  logic [11:0] dvd_q, dvd_d;
  logic [5:0]  dvs_q, dvs_d;
  logic [6:0]  r_q, r_d;
  logic [5:0]  qq_q, qq_d;
  logic [2:0]  cnt_q, cnt_d;
  logic [5:0]  quo_q, quo_d;
  logic [5:0]  rem_q, rem_d;
  logic        dz_q, dz_d;
  logic        ovf_q, ovf_d;

  // One restoring step: shift {R,Q} left and conditionally subtract the divisor.
  logic [7:0] r_sh;
  logic       r_ge;
  logic [6:0] r_step;
  logic [5:0] q_step;
  always_comb begin
    r_sh   = {r_q, qq_q[5]};
    r_ge   = (r_sh >= {2'b00, dvs_q});
    r_step = r_ge ? (r_sh[6:0] - {1'b0, dvs_q}) : r_sh[6:0];
    q_step = {qq_q[4:0], r_ge};
  end

  // Next-state, datapath update and status decode.
  always_comb begin
    state_d = state_q;
    dvd_d   = dvd_q;
    dvs_d   = dvs_q;
    r_d     = r_q;
    qq_d    = qq_q;
    cnt_d   = cnt_q;
    quo_d   = quo_q;
    rem_d   = rem_q;
    dz_d    = dz_q;
    ovf_d   = ovf_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          dvd_d   = dividend;
          dvs_d   = divisor;
          state_d = CHECK;
        end
      end
      CHECK: begin
        if (dvs_q == 6'd0) begin
          dz_d    = 1'b1;
          ovf_d   = 1'b0;
          quo_d   = 6'h3F;
          rem_d   = dvd_q[5:0];
          state_d = FIN;
        end else if (dvd_q[11:6] >= dvs_q) begin
          // The upper half already holds the divisor: quotient cannot fit in 6 bits.
          dz_d    = 1'b0;
          ovf_d   = 1'b1;
          quo_d   = 6'h3F;
          rem_d   = 6'h00;
          state_d = FIN;
        end else begin
          r_d     = {1'b0, dvd_q[11:6]};
          qq_d    = dvd_q[5:0];
          cnt_d   = 3'd0;
          state_d = RUN;
        end
      end
      RUN: begin
        r_d   = r_step;
        qq_d  = q_step;
        cnt_d = cnt_q + 3'd1;
        if (cnt_q == 3'd5) begin
          quo_d   = q_step;
          rem_d   = r_step[5:0];
          dz_d    = 1'b0;
          ovf_d   = 1'b0;
          state_d = FIN;
        end
      end
      FIN:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
    busy      = (state_q == CHECK) || (state_q == RUN);
    done      = (state_q == FIN);
    quotient  = quo_q;
    remainder = rem_q;
    dz        = dz_q;
    ovf       = ovf_q;
  end

  // State and datapath registers; reset clears every result and working register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      dvd_q   <= '0;
      dvs_q   <= '0;
      r_q     <= '0;
      qq_q    <= '0;
      cnt_q   <= '0;
      quo_q   <= '0;
      rem_q   <= '0;
      dz_q    <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      dvd_q   <= dvd_d;
      dvs_q   <= dvs_d;
      r_q     <= r_d;
      qq_q    <= qq_d;
      cnt_q   <= cnt_d;
      quo_q   <= quo_d;
      rem_q   <= rem_d;
      dz_q    <= dz_d;
      ovf_q   <= ovf_d;
    end
  end

endmodule

// File: tb/tb_seq_divider.sv
// Scoreboard bench for seq_divider: expected results are queued at accept time
// and compared, together with completion cycle, when done pulses.
module tb_seq_divider;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic [11:0] dividend = '0;
  logic [5:0]  divisor = '0;
  logic        busy, done, dz, ovf;
  logic [5:0]  quotient, remainder;

  seq_divider dut (
    .clk(clk), .rst(rst), .start(start), .dividend(dividend), .divisor(divisor),
    .busy(busy), .done(done), .quotient(quotient), .remainder(remainder),
    .dz(dz), .ovf(ovf)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [5:0] q;
    logic [5:0] r;
    logic       dz;
    logic       ovf;
    int         cyc;
  } exp_t;

  exp_t exp_q[$];
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input int obs, input int expv);
    checks++;
    if (obs !== expv) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, expv);
    end
  endtask

  // Reference model built from plain division; acc is cyc at the negedge before the accepting edge.
  function automatic exp_t model(input int dvd, input int dvs, input int acc);
    exp_t e;
    e.dz = 1'b0; e.ovf = 1'b0;
    if (dvs == 0) begin
      e.dz = 1'b1; e.q = 6'h3F; e.r = 6'(dvd % 64); e.cyc = acc + 2;
    end else if ((dvd / 64) >= dvs) begin
      e.ovf = 1'b1; e.q = 6'h3F; e.r = 6'h00; e.cyc = acc + 2;
    end else begin
      e.q = 6'(dvd / dvs); e.r = 6'(dvd % dvs); e.cyc = acc + 8;
    end
    return e;
  endfunction

  // Compare every done pulse against the head of the scoreboard.
  always @(negedge clk) begin
    if (!rst && done) begin
      if (exp_q.size() == 0) begin
        chk("spurious_done", 1, 0);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        chk("quotient", int'(quotient), int'(e.q));
        chk("remainder", int'(remainder), int'(e.r));
        chk("dz", int'(dz), int'(e.dz));
        chk("ovf", int'(ovf), int'(e.ovf));
        chk("done_cycle", cyc, e.cyc);
        chk("busy_in_fin", int'(busy), 0);
      end
    end
  end

  // Wait for the scoreboard to drain; a stuck DUT counts as a failure.
  task automatic wait_drain();
    int n = 0;
    while (exp_q.size() != 0 && n < 60) begin
      @(negedge clk); #1;
      n++;
    end
    if (exp_q.size() != 0) begin
      chk("timeout", exp_q.size(), 0);
      exp_q.delete();
    end
  endtask

  task automatic run_op(input int dvd, input int dvs);
    @(negedge clk);
    dividend = 12'(dvd); divisor = 6'(dvs); start = 1'b1;
    exp_q.push_back(model(dvd, dvs, cyc));
    @(negedge clk);
    start = 1'b0;
    dividend = 12'($urandom); divisor = 6'($urandom);
    wait_drain();
  endtask

  task automatic chk_cleared(input string tag);
    chk({tag, "_busy"}, int'(busy), 0);
    chk({tag, "_done"}, int'(done), 0);
    chk({tag, "_quo"}, int'(quotient), 0);
    chk({tag, "_rem"}, int'(remainder), 0);
    chk({tag, "_dz"}, int'(dz), 0);
    chk({tag, "_ovf"}, int'(ovf), 0);
  endtask

  initial begin
    int a;
    repeat (2) @(negedge clk);
    chk_cleared("reset");
    rst = 1'b0;

    run_op(100, 7);
    run_op(4031, 63);
    run_op(4032, 63);
    run_op(555, 0);
    run_op(1000, 9);
    run_op(63, 1);

    // Re-pulse start with other operands mid-RUN; outputs must still hold the last result.
    @(negedge clk);
    dividend = 12'd1000; divisor = 6'd17; start = 1'b1;
    a = cyc;
    exp_q.push_back(model(1000, 17, a));
    @(negedge clk); start = 1'b0;
    repeat (2) @(negedge clk);
    dividend = 12'd50; divisor = 6'd3; start = 1'b1;
    chk("hold_quo", int'(quotient), 63);
    chk("busy_run", int'(busy), 1);
    @(negedge clk); start = 1'b0;
    wait_drain();

    // Back-to-back: start held through FIN, re-accepted in the following IDLE cycle.
    @(negedge clk);
    dividend = 12'd2000; divisor = 6'd45; start = 1'b1;
    a = cyc;
    exp_q.push_back(model(2000, 45, a));
    exp_q.push_back(model(777, 0, a + 9));
    @(negedge clk);
    dividend = 12'd777; divisor = 6'd0;
    while (cyc < a + 10) @(negedge clk);
    start = 1'b0;
    wait_drain();

    // Reset during the third RUN cycle discards the operation.
    @(negedge clk);
    dividend = 12'd200; divisor = 6'd11; start = 1'b1;
    a = cyc;
    @(negedge clk); start = 1'b0;
    while (cyc < a + 4) @(negedge clk);
    chk("busy_before_rst", int'(busy), 1);
    rst = 1'b1;
    @(negedge clk);
    chk_cleared("mid_rst");
    rst = 1'b0;
    repeat (10) @(negedge clk);
    run_op(100, 7);

    // A few random legal operations.
    for (int i = 0; i < 6; i++) begin
      int dv, dd;
      dv = $urandom_range(63, 1);
      dd = $urandom_range(dv * 64 - 1, 0);
      run_op(dd, dv);
    end

    repeat (3) @(negedge clk);
    chk("queue_empty", exp_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
